uart_tx_sched: RTL and testbench

- Two-requester scheduler in front of the UART transmitter.
- Arbitrates byte requests round-robin and launches one frame at a time on the transmitter's data/valid interface.
- Holds parity configuration stable for the whole frame.
- Tracks the transmitter's busy handshake and flags an error if a launched frame is never accepted.

---
 rtl/uart_tx_pkg.sv | 13 +
 rtl/uart_tx_sched_if.sv | 28 ++
 rtl/uart_tx_sched_rr_arb2.sv | 16 +
 rtl/uart_tx_sched.sv | 138 +++++++++++++
 tb/tb_uart_tx_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and defaults.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_BUSY = 2'b01,
        WAIT_DONE = 2'b10
    } sched_state_e;

    localparam int unsigned UART_DATA_W  = 8;
    localparam int unsigned UART_TIMEOUT = 15;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Scheduler-to-transmitter link: launch byte, frame parity settings and busy handshake.
interface uart_tx_sched_if #(
    parameter int unsigned DATA_W = 8
);

    logic [DATA_W-1:0] tx_p_data;
    logic              tx_data_valid;
    logic              tx_par_en;
    logic              tx_par_typ;
    logic              tx_busy;

    modport master (
        output tx_p_data,
        output tx_data_valid,
        output tx_par_en,
        output tx_par_typ,
        input  tx_busy
    );

    modport slave (
        input  tx_p_data,
        input  tx_data_valid,
        input  tx_par_en,
        input  tx_par_typ,
        output tx_busy
    );

endinterface

// File: rtl/uart_tx_sched_rr_arb2.sv
// Combinational two-way round-robin chooser; the last-grant pointer lives in the caller.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_src,
    output logic valid,
    output logic sel
);

    always_comb begin
        valid = req0 | req1;
        // Under contention the requester that did not win last time goes next.
        sel   = (req0 & req1) ? ~last_src : req1;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler launching one frame at a time on the UART
// transmitter, with frame-stable parity settings and an acceptance timeout.
module uart_tx_sched
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = UART_DATA_W,
    parameter int unsigned TIMEOUT = UART_TIMEOUT,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [DATA_W-1:0]    data0,
    output logic                 gnt0,
    input  logic                 req1,
    input  logic [DATA_W-1:0]    data1,
    output logic                 gnt1,
    input  logic                 cfg_par_en,
    input  logic                 cfg_par_typ,
    input  logic                 err_clr,
    uart_tx_sched_if.master      tx,
    output logic                 sched_busy,
    output logic                 last_src,
    output logic                 timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_en_q, par_en_d;
    logic              par_typ_q, par_typ_d;
    logic              valid_q, valid_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              busy_q, busy_d;
    logic              last_src_q, last_src_d;
    logic              err_q, err_d;

    logic              arb_valid;
    logic              arb_sel;

    rr_arb2 u_arb (
        .req0     (req0),
        .req1     (req1),
        .last_src (last_src_q),
        .valid    (arb_valid),
        .sel      (arb_sel)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        valid_d    = 1'b0;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        last_src_d = last_src_q;
        err_d      = err_clr ? 1'b0 : err_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d    = WAIT_BUSY;
                    cnt_d      = '0;
                    data_d     = arb_sel ? data1 : data0;
                    par_en_d   = cfg_par_en;
                    par_typ_d  = cfg_par_typ;
                    valid_d    = 1'b1;
                    gnt0_d     = ~arb_sel;
                    gnt1_d     = arb_sel;
                    last_src_d = arb_sel;
                end
            end
            WAIT_BUSY: begin
                if (tx.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Set overrides a simultaneous err_clr; the byte is dropped.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            valid_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            busy_q     <= 1'b0;
            last_src_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            valid_q    <= valid_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            busy_q     <= busy_d;
            last_src_q <= last_src_d;
            err_q      <= err_d;
        end
    end

    assign tx.tx_p_data     = data_q;
    assign tx.tx_data_valid = valid_q;
    assign tx.tx_par_en     = par_en_q;
    assign tx.tx_par_typ    = par_typ_q;
    assign gnt0             = gnt0_q;
    assign gnt1             = gnt1_q;
    assign sched_busy       = busy_q;
    assign last_src         = last_src_q;
    assign timeout_err      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with hand-computed expectations.
module tb_uart_tx_sched;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1;
    logic       cfg_par_en, cfg_par_typ;
    logic       err_clr;
    logic       sched_busy, last_src, timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_sched_if #(.DATA_W(8)) tx_if ();

    uart_tx_sched #(
        .DATA_W  (8),
        .TIMEOUT (15),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .data0       (data0),
        .gnt0        (gnt0),
        .req1        (req1),
        .data1       (data1),
        .gnt1        (gnt1),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_typ (cfg_par_typ),
        .err_clr     (err_clr),
        .tx          (tx_if.master),
        .sched_busy  (sched_busy),
        .last_src    (last_src),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        cfg_par_en = 1'b0; cfg_par_typ = 1'b0; err_clr = 1'b0;
        tx_if.tx_busy = 1'b0;

        // Reset values
        #2 rst = 1'b0;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_valid", tx_if.tx_data_valid, 0);
        check("rst_data", tx_if.tx_p_data, 0);
        check("rst_par_en", tx_if.tx_par_en, 0);
        check("rst_busy", sched_busy, 0);
        check("rst_last_src", last_src, 1);
        check("rst_err", timeout_err, 0);
        @(negedge clk) rst = 1'b1;

        // Single launch, 11-cycle busy, cfg toggle mid-frame
        step();
        req0 = 1'b1; data0 = 8'hA5; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        step();
        check("t1_gnt0", gnt0, 1);
        check("t1_gnt1", gnt1, 0);
        check("t1_valid", tx_if.tx_data_valid, 1);
        check("t1_data", tx_if.tx_p_data, 8'hA5);
        check("t1_par_en", tx_if.tx_par_en, 1);
        check("t1_par_typ", tx_if.tx_par_typ, 0);
        check("t1_last_src", last_src, 0);
        check("t1_busy", sched_busy, 1);
        req0 = 1'b0; tx_if.tx_busy = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            check("t1_busy_hold", sched_busy, 1);
            if (i == 0) begin
                check("t1_valid_pulse", tx_if.tx_data_valid, 0);
                check("t1_gnt0_pulse", gnt0, 0);
            end
            if (i == 5) cfg_par_typ = 1'b1;
        end
        check("t1_par_typ_frozen", tx_if.tx_par_typ, 0);
        tx_if.tx_busy = 1'b0;
        step();
        check("t1_busy_fall", sched_busy, 0);
        check("t1_par_typ_idle", tx_if.tx_par_typ, 0);
        check("t1_data_hold", tx_if.tx_p_data, 8'hA5);

        // Timeout: transmitter never accepts
        cfg_par_en = 1'b0;
        req1 = 1'b1; data1 = 8'h3C;
        step();
        check("t2_gnt1", gnt1, 1);
        check("t2_gnt0", gnt0, 0);
        check("t2_valid", tx_if.tx_data_valid, 1);
        check("t2_data", tx_if.tx_p_data, 8'h3C);
        check("t2_par_en", tx_if.tx_par_en, 0);
        check("t2_par_typ", tx_if.tx_par_typ, 1);
        check("t2_last_src", last_src, 1);
        req1 = 1'b0;
        for (int i = 1; i < 15; i++) begin
            step();
            check("t2_err_early", timeout_err, 0);
            check("t2_busy_wait", sched_busy, 1);
        end
        step();
        check("t2_err_set", timeout_err, 1);
        check("t2_idle_after_to", sched_busy, 0);
        req0 = 1'b1; data0 = 8'h5A;
        step();
        check("t2_regrant", gnt0, 1);
        check("t2_regrant_data", tx_if.tx_p_data, 8'h5A);
        check("t2_err_sticky", timeout_err, 1);
        req0 = 1'b0; tx_if.tx_busy = 1'b1;
        step();
        tx_if.tx_busy = 1'b0;
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t2_err_clr", timeout_err, 0);

        // Timeout coinciding with err_clr: set wins
        req0 = 1'b1; data0 = 8'h66;
        step();
        check("t3_gnt0", gnt0, 1);
        req0 = 1'b0;
        for (int i = 1; i < 15; i++) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t3_set_wins", timeout_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t3_clr_after", timeout_err, 0);

        // req1 pulse during WAIT_DONE is not granted
        req0 = 1'b1; data0 = 8'h77;
        step();
        check("t4_gnt0", gnt0, 1);
        req0 = 1'b0; tx_if.tx_busy = 1'b1;
        step();
        req1 = 1'b1; data1 = 8'h88;
        step();
        req1 = 1'b0;
        check("t4_no_gnt1_a", gnt1, 0);
        step();
        check("t4_no_gnt1_b", gnt1, 0);
        tx_if.tx_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_no_gnt1_idle", gnt1, 0);
            check("t4_no_valid_idle", tx_if.tx_data_valid, 0);
        end

        // Asynchronous reset mid-frame
        req0 = 1'b1; data0 = 8'h99; cfg_par_en = 1'b1;
        step();
        check("t5_gnt0", gnt0, 1);
        req0 = 1'b0; tx_if.tx_busy = 1'b1;
        step();
        check("t5_wait_done", sched_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_data", tx_if.tx_p_data, 0);
        check("t5_rst_par_en", tx_if.tx_par_en, 0);
        check("t5_rst_par_typ", tx_if.tx_par_typ, 0);
        check("t5_rst_busy", sched_busy, 0);
        check("t5_rst_last_src", last_src, 1);
        @(negedge clk);
        rst = 1'b1; tx_if.tx_busy = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;

        // Both requesters held: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int w = 0; w < 6 && !seen; w++) begin
                step();
                if (tx_if.tx_data_valid === 1'b1) seen = 1'b1;
            end
            check("t6_grant_seen", 32'(seen), 1);
            check("t6_gnt0", gnt0, (k % 2 == 0) ? 1 : 0);
            check("t6_gnt1", gnt1, (k % 2 == 0) ? 0 : 1);
            check("t6_data", tx_if.tx_p_data, (k % 2 == 0) ? 8'h11 : 8'h22);
            tx_if.tx_busy = 1'b1;
            step();
            check("t6_valid_pulse", tx_if.tx_data_valid, 0);
            step();
            tx_if.tx_busy = 1'b0;
            step();
        end
        req0 = 1'b0; req1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
